jtag_hub_up_arbiter: RTL and testbench
======================================

# jtag_hub_up_arbiter

Upstream arbiter for the JTAG hub. It merges the four debug-function upstream byte streams (la, ioview, gdb, wfg) into one tagged 12-bit stream for the JTAG shift logic. Each word carries a 4-bit channel code and 8 data bits. It sits between the function blocks' `data_up_*` outputs and the hub's upstream shift register. Default arbitration is round-robin; fixed priority can be compiled in instead.

## Interface

Parameters
- `CODE_LA`, 4'hC, channel code prepended to la bytes
- `CODE_IOVIEW`, 4'hA, channel code for ioview
- `CODE_GDB`, 4'h9, channel code for gdb
- `CODE_WFG`, 4'hB, channel code for wfg

Ports
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `ce`  in  1  clock enable; state advances only when high
- `data_up_valid_la` / `_ioview` / `_gdb` / `_wfg`  in  1 each  source byte valid
- `data_up_la` / `_ioview` / `_gdb` / `_wfg`  in  8 each  source byte
- `data_up_ready_la` / `_ioview` / `_gdb` / `_wfg`  out  1 each  source byte accepted this cycle
- `up_data`  out  12  `{code[3:0], byte[7:0]}` toward the shift logic
- `up_valid`  out  1  `up_data` holds a word
- `up_ready`  in  1  shift logic takes the word this cycle
- `grant_id`  out  2  index of the last channel granted (0=la, 1=ioview, 2=gdb, 3=wfg)

## Operation

- Channel index order is la=0, ioview=1, gdb=2, wfg=3.
- There is a one-entry output register: `up_valid`, `up_data`.
- `load_ok = ce & !rst & (!up_valid | up_ready)`.
- The grant is combinational.
  - Search the valid channels starting at pointer `ptr[1:0]`, wrapping 3→0.
  - The first valid channel found wins.
  - The winner's `data_up_ready_*` equals `load_ok`. All other readies are 0.
- Source handshake: a transfer happens when valid & ready are high in the same cycle. A source must hold valid and data stable until it sees ready.
- On a transfer, at the posedge:
  - `up_data <= {CODE_x, byte_x}`, `up_valid <= 1`.
  - `ptr <= winner+1` (mod 4), `grant_id <= winner`.
- When `up_valid & up_ready & ce` and no new transfer happens: `up_valid <= 0`. `up_data` keeps its value.
- Pass-through: an accept and a new load in the same cycle replace the word. Sustained throughput is 1 word/cycle.
- No valid source: `ptr` is unchanged and no ready is asserted.
- `ce` low: every ready is 0, all registers hold, and `up_valid` and `up_data` stay stable.
- Reset values: `up_valid=0`, `up_data=12'h000`, `ptr=0`, `grant_id=0`. All `data_up_ready_*` are 0 while `rst` is high.
- Reset mid-operation: a held word is dropped and no source transfer completes in the reset cycle.

## Timing

- Latency from source transfer to `up_valid`: 1 cycle.
- Readies are combinational from the source valids, `ptr`, `up_valid`, `up_ready` and `ce`. There is no registered path from `up_ready` to the source readies beyond `load_ok`.
- All four sources continuously valid: grants rotate la, ioview, gdb, wfg, la…, one per cycle while `up_ready=1`.
- Backpressure (`up_valid=1`, `up_ready=0`): no source is granted and `ptr` freezes.
- Fairness: a continuously valid channel is granted within 4 transfers.

## Configuration

- Macro: `JTAG_HUB_UP_ARB_FIXED_PRIORITY_EN`.
- Defined: the search always starts at index 0, so la > ioview > gdb > wfg. `ptr` is not implemented. `grant_id` still reports the winner.
- Undefined: round-robin as described above.

## Test plan

- Reset: assert `rst` for 2 cycles with all sources valid. Expect `up_valid=0`, `up_data=000`, all readies 0. After release the first grant goes to la (`ptr=0`).
- Single source: gdb sends byte 0x5A with `up_ready=1`. `data_up_ready_gdb` pulses for 1 cycle, then next cycle `up_valid=1`, `up_data=12'h95A`, `grant_id=2`.
- Round-robin: all four valid with bytes 11/22/33/44 and `up_ready=1`. Words arrive on consecutive cycles as C11, A22, 933, B44, then C11 again.
- Backpressure: `up_ready=0` with la and wfg valid. The first word is held, no further readies assert, and `ptr` is frozen. Raise `up_ready`: the next word follows in the same cycle it is accepted.
- ce gating: drop `ce` for 3 cycles mid-stream. No readies assert and outputs are unchanged. The sequence resumes with no loss or duplication.
- With `JTAG_HUB_UP_ARB_FIXED_PRIORITY_EN` and la and ioview continuously valid: only la is granted (`grant_id=0` every word). ioview is granted only once la drops valid.

Source files
------------

// File: rtl/jtag_hub_up_arbiter.sv
// Upstream arbiter for the JTAG hub: merges la/ioview/gdb/wfg byte streams into one 12-bit {code, byte} stream.
// Define JTAG_HUB_UP_ARB_FIXED_PRIORITY_EN for fixed priority (la > ioview > gdb > wfg) instead of round-robin.
module jtag_hub_up_arbiter #(
    parameter logic [3:0] CODE_LA     = 4'hC,
    parameter logic [3:0] CODE_IOVIEW = 4'hA,
    parameter logic [3:0] CODE_GDB    = 4'h9,
    parameter logic [3:0] CODE_WFG    = 4'hB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        data_up_valid_la,
    input  logic        data_up_valid_ioview,
    input  logic        data_up_valid_gdb,
    input  logic        data_up_valid_wfg,
    input  logic [7:0]  data_up_la,
    input  logic [7:0]  data_up_ioview,
    input  logic [7:0]  data_up_gdb,
    input  logic [7:0]  data_up_wfg,
    output logic        data_up_ready_la,
    output logic        data_up_ready_ioview,
    output logic        data_up_ready_gdb,
    output logic        data_up_ready_wfg,
    output logic [11:0] up_data,
    output logic        up_valid,
    input  logic        up_ready,
    output logic [1:0]  grant_id
);

    // Handshakes on both sides are valid/ready: a word moves on a cycle where valid and ready are
    // both high (and ce is high); the sender holds valid and data stable until it sees ready.

    logic [3:0]  vld;
    logic [1:0]  start;
    logic [1:0]  idx;
    logic [1:0]  winner;
    logic        found;
    logic        load_ok;
    logic        transfer;
    logic [11:0] win_word;

    assign vld      = {data_up_valid_wfg, data_up_valid_gdb, data_up_valid_ioview, data_up_valid_la};
    assign load_ok  = ce & ~rst & (~up_valid | up_ready);
    assign transfer = load_ok & found;

`ifdef JTAG_HUB_UP_ARB_FIXED_PRIORITY_EN
    assign start = 2'd0;
`else
    logic [1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (transfer) begin
            ptr <= winner + 2'd1;
        end
    end

    assign start = ptr;
`endif

    // First valid channel at or after start, wrapping 3 -> 0.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + i[1:0];
            if (!found && vld[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_word = 12'h000;
        case (winner)
            2'd0:    win_word = {CODE_LA,     data_up_la};
            2'd1:    win_word = {CODE_IOVIEW, data_up_ioview};
            2'd2:    win_word = {CODE_GDB,    data_up_gdb};
            default: win_word = {CODE_WFG,    data_up_wfg};
        endcase
    end

    assign data_up_ready_la     = transfer & (winner == 2'd0);
    assign data_up_ready_ioview = transfer & (winner == 2'd1);
    assign data_up_ready_gdb    = transfer & (winner == 2'd2);
    assign data_up_ready_wfg    = transfer & (winner == 2'd3);

    // A load in the same cycle as an accept replaces the word, giving one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid <= 1'b0;
            up_data  <= 12'h000;
            grant_id <= 2'd0;
        end else if (transfer) begin
            up_valid <= 1'b1;
            up_data  <= win_word;
            grant_id <= winner;
        end else if (ce && up_valid && up_ready) begin
            up_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_hub_up_arbiter.sv
// Table-driven cycle vectors for jtag_hub_up_arbiter plus a hand-written same-cycle ready sequence.
// Bytes are la=11, ioview=22, wfg=44, gdb per vector; readies are {wfg, gdb, ioview, la}.
module tb_jtag_hub_up_arbiter;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic        v_la, v_io, v_gdb, v_wfg;
    logic [7:0]  d_la, d_io, d_gdb, d_wfg;
    logic        r_la, r_io, r_gdb, r_wfg;
    logic [11:0] up_data;
    logic        up_valid, up_ready;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_hub_up_arbiter dut (
        .clk(clk), .rst(rst), .ce(ce),
        .data_up_valid_la(v_la), .data_up_valid_ioview(v_io),
        .data_up_valid_gdb(v_gdb), .data_up_valid_wfg(v_wfg),
        .data_up_la(d_la), .data_up_ioview(d_io), .data_up_gdb(d_gdb), .data_up_wfg(d_wfg),
        .data_up_ready_la(r_la), .data_up_ready_ioview(r_io),
        .data_up_ready_gdb(r_gdb), .data_up_ready_wfg(r_wfg),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready), .grant_id(grant_id)
    );

    typedef struct {
        logic       rst;
        logic       ce;
        logic [3:0] vld;
        logic       ur;
        logic [7:0] gdb_b;
        logic [3:0] exp_rdy;
        logic       exp_uv;
        logic [11:0] exp_data;
        logic [1:0] exp_gid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic [3:0] v, logic u, logic [7:0] gb,
                                logic [3:0] er, logic euv, logic [11:0] ed, logic [1:0] eg);
        vec_t t;
        t.rst = r; t.ce = c; t.vld = v; t.ur = u; t.gdb_b = gb;
        t.exp_rdy = er; t.exp_uv = euv; t.exp_data = ed; t.exp_gid = eg;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        return {r_wfg, r_gdb, r_io, r_la};
    endfunction

    task automatic drive(input logic r, input logic c, input logic [3:0] v, input logic u,
                         input logic [7:0] gb);
        rst = r; ce = c; up_ready = u; d_gdb = gb;
        {v_wfg, v_gdb, v_io, v_la} = v;
    endtask

    initial begin
        d_la = 8'h11; d_io = 8'h22; d_wfg = 8'h44;
        drive(1'b1, 1'b1, 4'hF, 1'b1, 8'h33);

`ifdef JTAG_HUB_UP_ARB_FIXED_PRIORITY_EN
        vecs.push_back(mk(1, 1, 4'h3, 1, 8'h33, 4'h0, 0, 12'h000, 2'd0));
        vecs.push_back(mk(0, 1, 4'h3, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'h3, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'h3, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'h2, 1, 8'h33, 4'h2, 1, 12'hA22, 2'd1));
        vecs.push_back(mk(0, 1, 4'h0, 1, 8'h33, 4'h0, 0, 12'hA22, 2'd1));
`else
        // reset with all sources valid
        vecs.push_back(mk(1, 1, 4'hF, 1, 8'h33, 4'h0, 0, 12'h000, 2'd0));
        vecs.push_back(mk(1, 1, 4'hF, 1, 8'h33, 4'h0, 0, 12'h000, 2'd0));
        // round-robin rotation
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h2, 1, 12'hA22, 2'd1));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h4, 1, 12'h933, 2'd2));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h8, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        // single source gdb
        vecs.push_back(mk(0, 1, 4'h4, 1, 8'h5A, 4'h4, 1, 12'h95A, 2'd2));
        vecs.push_back(mk(0, 1, 4'h0, 1, 8'h5A, 4'h0, 0, 12'h95A, 2'd2));
        // backpressure with la and wfg
        vecs.push_back(mk(0, 1, 4'h9, 0, 8'h33, 4'h8, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 1, 4'h9, 0, 8'h33, 4'h0, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 1, 4'h9, 0, 8'h33, 4'h0, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 1, 4'h9, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'h9, 1, 8'h33, 4'h8, 1, 12'hB44, 2'd3));
        // ce low for three cycles
        vecs.push_back(mk(0, 0, 4'hF, 1, 8'h33, 4'h0, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 0, 4'hF, 1, 8'h33, 4'h0, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 0, 4'hF, 1, 8'h33, 4'h0, 1, 12'hB44, 2'd3));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h1, 1, 12'hC11, 2'd0));
        vecs.push_back(mk(0, 1, 4'hF, 1, 8'h33, 4'h2, 1, 12'hA22, 2'd1));
        // reset mid-operation drops the held word and resets ptr
        vecs.push_back(mk(1, 1, 4'hF, 0, 8'h33, 4'h0, 0, 12'h000, 2'd0));
        vecs.push_back(mk(0, 1, 4'h4, 0, 8'h33, 4'h4, 1, 12'h933, 2'd2));
        vecs.push_back(mk(0, 1, 4'h0, 1, 8'h33, 4'h0, 0, 12'h933, 2'd2));
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].ce, vecs[n].vld, vecs[n].ur, vecs[n].gdb_b);
            #1;
            check($sformatf("v%0d ready", n), 32'(rdy_vec()), 32'(vecs[n].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d up_valid", n), 32'(up_valid), 32'(vecs[n].exp_uv));
            check($sformatf("v%0d up_data", n), 32'(up_data), 32'(vecs[n].exp_data));
            check($sformatf("v%0d grant_id", n), 32'(grant_id), 32'(vecs[n].exp_gid));
        end

        // Hand sequence: la alone; then with the word held, ready must follow up_ready in the same cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h1, 1'b0, 8'h33);
        #1;
        check("seq first ready", 32'(rdy_vec()), 32'h1);
        @(posedge clk);
        #1;
        check("seq first word", 32'(up_data), 32'hC11);
        check("seq first valid", 32'(up_valid), 32'h1);
        @(negedge clk);
        #1;
        check("seq held ready", 32'(rdy_vec()), 32'h0);
        up_ready = 1'b1;
        #1;
        check("seq comb ready", 32'(rdy_vec()), 32'h1);
        @(posedge clk);
        #1;
        check("seq pass word", 32'(up_data), 32'hC11);
        check("seq pass valid", 32'(up_valid), 32'h1);
        check("seq pass gid", 32'(grant_id), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h0, 1'b1, 8'h33);
        @(posedge clk);
        #1;
        check("seq drain valid", 32'(up_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
